// File: rtl/control_pkg.sv
// Shared control definitions: opcodes, ALU/operand-select codes, the
// multi-cycle state encoding and the bundle of datapath control strobes.
package control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_JUMP  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_ALU  = 4'd2,
    S_EX_ADDR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_WB_ALU  = 4'd6,
    S_WB_MEM  = 4'd7,
    S_EX_BR   = 4'd8,
    S_EX_JMP  = 4'd9,
    S_TRAP    = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       retire;
    logic       trap;
  } ctrl_t;

  // Instruction class dispatch out of DECODE; unknown opcodes trap.
  function automatic state_e decode_next(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE: return S_EX_ALU;
      OP_LOAD, OP_STORE:  return S_EX_ADDR;
      OP_BRANCH:          return S_EX_BR;
      OP_JAL:             return S_EX_JMP;
      default:            return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle. master = control unit.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_2_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       branch;
  logic       jump;
  logic       retire;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read,
           mem_write, mem_2_reg, alu_src_a, alu_src_b, alu_op, reg_write,
           branch, jump, retire, trap, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read,
           mem_write, mem_2_reg, alu_src_a, alu_src_b, alu_op, reg_write,
           branch, jump, retire, trap, state
  );
endinterface

// File: rtl/wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles inside one wait
// state and flags the cycle on which one more miss would exceed TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over tick so each wait state starts counting from zero.
  // With TIMEOUT=0 the counter may wrap; expired is held low regardless.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)       cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (tick)  cnt_q <= cnt_q + 1'b1;
  end

  // Fires only on a not-ready cycle, so a same-cycle ready never traps.
  assign expired = (TIMEOUT != 0) && tick && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencing with memory-ready handshake, watchdog and illegal-opcode trap.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  multicycle_control_unit_if.master  bus
);

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic       wait_st, tick, expired;
  ctrl_t      ctrl;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign tick    = wait_st && !bus.mem_ready;

  // Any state change restarts the count, covering entry to every wait state.
  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .arst    (arst),
    .clear   (state_d != state_q),
    .tick    (tick),
    .expired (expired)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
                 else if (expired)  state_d = S_TRAP;
      S_DECODE:  state_d = decode_next(bus.opcode);
      S_EX_ALU:  state_d = S_WB_ALU;
      S_EX_ADDR: state_d = (op_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (bus.mem_ready) state_d = S_WB_MEM;
                 else if (expired)  state_d = S_TRAP;
      S_MEM_WR:  if (bus.mem_ready) state_d = S_FETCH;
                 else if (expired)  state_d = S_TRAP;
      S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JMP: state_d = S_FETCH;
      default:   state_d = S_TRAP;
    endcase
  end

  // State register; the opcode is captured while DECODE is current.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end

  // Output decode from state; only FETCH strobes and MEM_WR retire look at mem_ready.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EX_ALU: begin
        ctrl.alu_src_a = 1'b1;
        if (op_q == OP_RTYPE) begin
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALU_RTYPE;
        end else begin
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
      end
      S_EX_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = bus.mem_ready;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_2_reg = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_EX_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.branch        = 1'b1;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
        ctrl.retire        = 1'b1;
      end
      S_EX_JMP: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_JUMP;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = 1'b1;
        ctrl.retire    = 1'b1;
      end
      default: ctrl.trap = 1'b1;
    endcase
    // Reset silences the datapath immediately, not at the next edge.
    if (arst) ctrl = '0;
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.mem_2_reg     = ctrl.mem_2_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.branch        = ctrl.branch;
  assign bus.jump          = ctrl.jump;
  assign bus.retire        = ctrl.retire;
  assign bus.trap          = ctrl.trap;
  assign bus.state         = arst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios then random opcode /
// mem_ready traffic, checked every cycle against an instruction-sequence model.
module tb_multicycle_control_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic arst;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: the list of state codes the current instruction still has to visit.
  int         seq[$];
  int         m_wait;
  logic [6:0] m_op;
  int         trap_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_ctrl();
    return {13'd0, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.ir_write,
            bus.i_or_d, bus.mem_read, bus.mem_write, bus.mem_2_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.reg_write, bus.branch, bus.jump,
            bus.retire, bus.trap};
  endfunction

  // Expected strobes for a state code, straight from the per-state output table.
  function automatic logic [31:0] exp_ctrl(input int st, input logic rdy, input logic [6:0] op);
    logic pw, pwc, ps, irw, iod, mr, mw, m2r, asa, rw, br, jp, ret, tr;
    logic [1:0] asb, aop;
    {pw, pwc, ps, irw, iod, mr, mw, m2r, asa, rw, br, jp, ret, tr} = '0;
    asb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b10;
      2:  begin asa = 1; if (op == 7'b0110011) aop = 2'b10; else asb = 2'b10; end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin mw = 1; iod = 1; ret = rdy; end
      6:  begin rw = 1; ret = 1; end
      7:  begin rw = 1; m2r = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; br = 1; pwc = 1; ps = 1; ret = 1; end
      9:  begin jp = 1; rw = 1; asb = 2'b01; aop = 2'b11; pw = 1; ps = 1; ret = 1; end
      default: tr = 1;
    endcase
    return {13'd0, pw, pwc, ps, irw, iod, mr, mw, m2r, asa, asb, aop, rw, br, jp, ret, tr};
  endfunction

  function automatic bit is_wait(input int st);
    return (st == 0) || (st == 4) || (st == 5);
  endfunction

  task automatic model_reset();
    seq = '{0, 1};
    m_wait = 0;
    m_op = '0;
    trap_cycles = 0;
  endtask

  // Advance the model across one rising edge.
  task automatic model_step(input logic [6:0] op, input logic rdy);
    int cur;
    cur = seq[0];
    if (cur == 15) begin trap_cycles++; return; end
    if (is_wait(cur) && !rdy) begin
      if (m_wait == TO - 1) seq = '{15};
      else m_wait++;
      return;
    end
    m_wait = 0;
    void'(seq.pop_front());
    if (cur == 1) begin
      m_op = op;
      case (op)
        7'b0110011, 7'b0010011: seq = '{2, 6};
        7'b0000011:             seq = '{3, 4, 7};
        7'b0100011:             seq = '{3, 5};
        7'b1100011:             seq = '{8};
        7'b1101111:             seq = '{9};
        default:                seq = '{15};
      endcase
    end
    if (seq.size() == 0) seq = '{0, 1};
  endtask

  // One clock: drive at negedge, check 1ns later, step model, wait next negedge.
  task automatic run_cycle(input logic [6:0] op, input logic rdy);
    opcode_drive(op, rdy);
    #1;
    chk("state", {28'd0, bus.state}, seq[0]);
    chk("ctrl", obs_ctrl(), exp_ctrl(seq[0], rdy, (seq[0] == 1) ? op : m_op));
    model_step(op, rdy);
    @(negedge clk);
  endtask

  task automatic opcode_drive(input logic [6:0] op, input logic rdy);
    bus.opcode = op;
    bus.mem_ready = rdy;
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    #1;
    chk("rst_ctrl", obs_ctrl(), 32'd0);
    chk("rst_state", {28'd0, bus.state}, 32'd0);
    @(negedge clk);
    chk("rst_hold", obs_ctrl(), 32'd0);
    arst = 1'b0;
    model_reset();
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] legal [6];
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    if ($urandom_range(0, 19) == 0) return 7'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    arst = 1'b1;
    opcode_drive(7'd0, 1'b0);
    model_reset();
    @(negedge clk);
    pulse_reset();

    // R-type, zero wait: 0,1,2,6
    run_cycle(7'h00, 1); run_cycle(7'b0110011, 1); run_cycle(7'h00, 1); run_cycle(7'h00, 1);
    // I-type
    run_cycle(7'h00, 1); run_cycle(7'b0010011, 1); run_cycle(7'h00, 1); run_cycle(7'h00, 1);
    // Load with three not-ready cycles in MEM_RD: 8 cycles total
    run_cycle(7'h00, 1); run_cycle(7'b0000011, 1); run_cycle(7'h00, 1);
    run_cycle(7'h00, 0); run_cycle(7'h00, 0); run_cycle(7'h00, 0); run_cycle(7'h00, 1);
    run_cycle(7'h00, 1);
    // Branch: 3 cycles
    run_cycle(7'h00, 1); run_cycle(7'b1100011, 1); run_cycle(7'h00, 1);
    // Store with one wait
    run_cycle(7'h00, 1); run_cycle(7'b0100011, 1); run_cycle(7'h00, 1);
    run_cycle(7'h00, 0); run_cycle(7'h00, 1);
    // Ready on the limit cycle: no trap, then a jump
    run_cycle(7'h00, 0); run_cycle(7'h00, 0); run_cycle(7'h00, 0); run_cycle(7'h00, 1);
    run_cycle(7'b1101111, 1); run_cycle(7'h00, 1);
    // FETCH timeout: trap after four not-ready cycles, trap held
    for (int i = 0; i < 4; i++) run_cycle(7'h00, 0);
    for (int i = 0; i < 3; i++) run_cycle(7'h00, 1);
    pulse_reset();
    // Illegal opcode traps from DECODE and never retires
    run_cycle(7'h00, 1); run_cycle(7'b1111111, 1);
    for (int i = 0; i < 3; i++) run_cycle(7'h00, 1);
    pulse_reset();
    // Reset while MEM_WR is active
    run_cycle(7'h00, 1); run_cycle(7'b0100011, 1); run_cycle(7'h00, 1);
    opcode_drive(7'h00, 1'b0);
    #1;
    chk("memwr_pre", {31'd0, bus.mem_write}, 32'd1);
    pulse_reset();
    run_cycle(7'h00, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (trap_cycles >= 3 || $urandom_range(0, 299) == 0) pulse_reset();
      else run_cycle(rand_op(), ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RISC-V control FSM, successor to the single-cycle decoder. Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. Drives the shared-memory multi-cycle datapath (IR, old-PC, ALUOut, MDR registers), waits on a memory ready handshake, and traps on illegal opcodes or memory timeout.

## Interface
- TIMEOUT, 16: maximum consecutive not-ready cycles tolerated in any memory wait state; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1): wait-counter width, derived, not overridden.
- clk  in  1  clock, all state on rising edge.
- arst  in  1  asynchronous active-high reset.
- opcode  in  7  IR[6:0]; only required valid during DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs).
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- ir_write  out  1  load IR and old-PC register.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1  memory strobes.
- mem_2_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  0 = old PC/PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 ADD, 01 SUB, 10 R-type, 11 JUMP.
- reg_write, branch, jump  out  1  as in the single-cycle unit.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- trap  out  1  high while in TRAP.
- state  out  4  current state code (debug).

## Operation
States (4-bit codes): FETCH 0, DECODE 1, EX_ALU 2, EX_ADDR 3, MEM_RD 4, MEM_WR 5, WB_ALU 6, WB_MEM 7, EX_BR 8, EX_JMP 9, TRAP 15. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD. When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=ADD, which computes the target into ALUOut. Latch opcode into op_q. Next state:
  - 0110011 or 0010011 → EX_ALU
  - 0000011 or 0100011 → EX_ADDR
  - 1100011 → EX_BR
  - 1101111 → EX_JMP
  - anything else → TRAP
- EX_ALU: alu_src_a=1. For R-type, alu_src_b=00 and alu_op=R-type. For I-type, alu_src_b=10 and alu_op=ADD. Next state WB_ALU.
- EX_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, i_or_d=1. When mem_ready=1, go to WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1. When mem_ready=1, assert retire and go to FETCH.
- WB_ALU: reg_write=1, mem_2_reg=0, retire=1. Next state FETCH.
- WB_MEM: reg_write=1, mem_2_reg=1, retire=1. Next state FETCH.
- EX_BR: alu_src_a=1, alu_src_b=00, alu_op=SUB, branch=1, pc_write_cond=1, pc_src=1, retire=1. Next state FETCH.
- EX_JMP: jump=1, reg_write=1, mem_2_reg=0, alu_src_a=0, alu_src_b=01, alu_op=JUMP (rd ← old PC+4), pc_write=1, pc_src=1, retire=1. Next state FETCH.
- TRAP: all strobes 0, trap=1. Leaves only on reset.
- Watchdog, in FETCH/MEM_RD/MEM_WR:
  - wait_cnt clears on entry to each of these states.
  - It increments on each cycle with mem_ready=0.
  - If mem_ready=0 and wait_cnt==TIMEOUT-1, go to TRAP.
  - mem_ready=1 on the limit cycle wins: normal transition, no trap.
- Reset: state=FETCH, op_q=0, wait_cnt=0. While arst is high, every output is forced to 0 combinationally and state reads 0. Reset mid-instruction abandons it with no further strobes.

## Timing
- Mealy outputs: ir_write, pc_write in FETCH and retire in MEM_WR depend on same-cycle mem_ready. All other outputs are decoded from the registered state only.
- Minimum latency with zero-wait memory:
  - R-type, I-type, load-less ALU: 4 cycles (FETCH, DECODE, EX, WB).
  - Branch, jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each not-ready cycle adds exactly one cycle.
- retire pulses exactly once per completed instruction, never in TRAP.

## Structure
- Package control_pkg: opcode constants, ALUOp codes, alu_src_b codes, state enum/localparams. Shared with the single-cycle control_unit and the datapath.
- Sub-module wait_timer: parameter TIMEOUT; inputs clk, arst, clear, tick; output expired.
- FSM next-state and output decode stay in multicycle_control_unit.

## Test plan
- R-type (opcode 0110011), mem_ready always 1 → states 0,1,2,6,0. alu_op=10 in EX_ALU. reg_write and retire in cycle 4.
- Load (0000011), mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles. WB_MEM has mem_2_reg=1. Total 8 cycles.
- Branch (1100011) → EX_BR asserts pc_write_cond, alu_op=01, pc_src=1. Returns to FETCH after 3 cycles.
- TIMEOUT=4, mem_ready held 0 in FETCH → TRAP after 4 cycles, trap=1 stays. Variant: mem_ready=1 on cycle 4 → DECODE, no trap.
- Illegal opcode 1111111 → DECODE → TRAP, no retire. Recovery only by arst.
- arst pulsed while in MEM_WR → mem_write drops immediately. After release, state=FETCH, and mem_read=1 next cycle.
